// File: rtl/ram_port_arbiter.sv
// Shares one single-port read-first RAM between a fetch port and a load/store port, with RMW for sub-word stores.
// Optional round-robin arbitration under contention: define RAM_ARB_ROUND_ROBIN_EN.
module ram_port_arbiter #(
    parameter int MEM_WORDS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_din_o,
    input  logic [31:0]           ram_dout_i
);

    typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

    // In-flight response: owner port, error flag, and whether rdata comes from the RAM.
    typedef struct packed {
        logic vld;
        logic own_data;
        logic err;
        logic rd;
    } resp_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            be;
        logic [31:0]           wdata;
    } rmw_t;

    state_t state_q, state_d;
    resp_t  resp_q, resp_d;
    rmw_t   rmw_q, rmw_d;

    logic        can_grant, data_first, gnt_data, gnt_instr;
    logic        data_err, instr_err, be_full, be_none, rmw_start;
    logic [31:0] merged;

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) ||
               ({2'b00, a[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_WORDS));
    endfunction

    assign can_grant = rstn && (state_q != RMW_WR);
    assign gnt_data  = can_grant && data_req_i && (data_first || !instr_req_i);
    assign gnt_instr = can_grant && instr_req_i && !gnt_data;
    assign data_err  = addr_bad(data_addr_i);
    assign instr_err = addr_bad(instr_addr_i);
    assign be_full   = (data_be_i == 4'b1111);
    assign be_none   = (data_be_i == 4'b0000);
    assign rmw_start = gnt_data && data_we_i && !data_err && !be_full && !be_none;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic prio_data_q, prio_data_d;

    // Pointer moves to the loser only when both ports actually competed for a grant.
    always_comb begin
        prio_data_d = prio_data_q;
        if (can_grant && data_req_i && instr_req_i)
            prio_data_d = !prio_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) prio_data_q <= 1'b1;
        else       prio_data_q <= prio_data_d;
    end

    assign data_first = prio_data_q;
`else
    assign data_first = 1'b1;
`endif

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = rmw_q.be[i] ? rmw_q.wdata[8*i +: 8] : ram_dout_i[8*i +: 8];
    end

    always_comb begin
        state_d    = state_q;
        resp_d     = '0;
        rmw_d      = rmw_q;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        case (state_q)
            RMW_WR: begin
                ram_we_o        = 1'b1;
                ram_addr_o      = rmw_q.addr;
                ram_din_o       = merged;
                resp_d.vld      = 1'b1;
                resp_d.own_data = 1'b1;
                state_d         = RESP;
            end
            default: begin
                state_d = IDLE;
                if (gnt_data) begin
                    ram_addr_o = data_addr_i;
                    ram_din_o  = data_wdata_i;
                    ram_we_o   = data_we_i && !data_err && be_full;
                    if (rmw_start) begin
                        // Read the old word now; the merged write goes out next cycle.
                        state_d     = RMW_WR;
                        rmw_d.addr  = data_addr_i;
                        rmw_d.be    = data_be_i;
                        rmw_d.wdata = data_wdata_i;
                    end else begin
                        resp_d.vld      = 1'b1;
                        resp_d.own_data = 1'b1;
                        resp_d.err      = data_err;
                        resp_d.rd       = !data_we_i && !data_err;
                    end
                end else if (gnt_instr) begin
                    ram_addr_o      = instr_addr_i;
                    resp_d.vld      = 1'b1;
                    resp_d.own_data = 1'b0;
                    resp_d.err      = instr_err;
                    resp_d.rd       = !instr_err;
                end
            end
        endcase
        if (!rstn)
            ram_we_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            resp_q  <= '0;
            rmw_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            rmw_q   <= rmw_d;
        end
    end

    assign data_gnt_o     = gnt_data;
    assign instr_gnt_o    = gnt_instr;
    assign data_rvalid_o  = resp_q.vld && resp_q.own_data;
    assign instr_rvalid_o = resp_q.vld && !resp_q.own_data;
    assign data_err_o     = data_rvalid_o && resp_q.err;
    assign instr_err_o    = instr_rvalid_o && resp_q.err;
    assign data_rdata_o   = (data_rvalid_o && resp_q.rd) ? ram_dout_i : '0;
    assign instr_rdata_o  = (instr_rvalid_o && resp_q.rd) ? ram_dout_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-first RAM and a preload port.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_din, ram_dout;

    logic [31:0] mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.MEM_WORDS(64), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_val;
        else if (ram_we) mem[ram_addr[7:2]] <= ram_din;
        ram_dout <= mem[ram_addr[7:2]];
    end

    typedef struct {
        logic        is_instr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        logic        exp_we;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_we  = 1'b1;
        pl_idx = idx[5:0];
        pl_val = val;
        cyc();
        pl_we  = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic we_seen;
        int   nd, ni;

        rstn = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_val = '0;
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF; data_addr = '0; data_wdata = '0;
        cyc();
        preload(2,  32'hDEADBEEF);
        preload(4,  32'h11223344);
        preload(6,  32'hA0A0A0A0);
        preload(63, 32'h5A5A0001);

        // Reset held 3 cycles with both requests up
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
        instr_req = 1'b1; instr_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_dgnt", i), data_gnt, 0);
            chk($sformatf("rst%0d_ignt", i), instr_gnt, 0);
            chk($sformatf("rst%0d_dvld", i), data_rvalid, 0);
            chk($sformatf("rst%0d_ivld", i), instr_rvalid, 0);
            chk($sformatf("rst%0d_rdata", i), data_rdata | instr_rdata, 0);
            chk($sformatf("rst%0d_we", i), ram_we, 0);
            cyc();
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_dgnt", data_gnt, 1);
        chk("post_rst_ignt", instr_gnt, 0);
        cyc();
        data_req = 1'b0;
        @(negedge clk);
        chk("post_rst_dvld", data_rvalid, 1);
        chk("post_rst_drdata", data_rdata, 32'hDEADBEEF);
        chk("post_rst_ignt2", instr_gnt, 1);
        chk("post_rst_ivld0", instr_rvalid, 0);
        cyc();
        instr_req = 1'b0;
        @(negedge clk);
        chk("post_rst_ivld", instr_rvalid, 1);
        chk("post_rst_irdata", instr_rdata, 32'h11223344);
        chk("post_rst_dvld0", data_rvalid, 0);
        cyc();

        // Sub-word store with a fetch arriving during the write cycle
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0101; data_addr = 32'h10; data_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("rmw_gnt", data_gnt, 1);
        chk("rmw_n_we", ram_we, 0);
        cyc();
        data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h8;
        @(negedge clk);
        chk("rmw_wr_we", ram_we, 1);
        chk("rmw_wr_din", ram_din, 32'h11BB33DD);
        chk("rmw_wr_addr", ram_addr, 32'h10);
        chk("rmw_wr_ignt", instr_gnt, 0);
        chk("rmw_wr_dvld", data_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("rmw_resp_dvld", data_rvalid, 1);
        chk("rmw_resp_rdata", data_rdata, 0);
        chk("rmw_resp_err", data_err, 0);
        chk("rmw_resp_ignt", instr_gnt, 1);
        cyc();
        instr_req = 1'b0;
        @(negedge clk);
        chk("rmw_fetch_ivld", instr_rvalid, 1);
        chk("rmw_fetch_rdata", instr_rdata, 32'hDEADBEEF);
        chk("rmw_fetch_dvld", data_rvalid, 0);
        cyc();
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h10;
        @(negedge clk);
        chk("rmw_ld_gnt", data_gnt, 1);
        cyc();
        data_req = 1'b0;
        @(negedge clk);
        chk("rmw_ld_rdata", data_rdata, 32'h11BB33DD);
        cyc();

        // Contention for 6 cycles
        nd = 0; ni = 0;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h8;
        instr_req = 1'b1; instr_addr = 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_one_gnt", i), 32'(data_gnt) + 32'(instr_gnt), 1);
            nd += int'(data_gnt);
            ni += int'(instr_gnt);
            cyc();
        end
        data_req = 1'b0; instr_req = 1'b0;
        cyc();
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("cont_data_grants", nd, 3);
        chk("cont_instr_grants", ni, 3);
`else
        chk("cont_data_grants", nd, 6);
        chk("cont_instr_grants", ni, 0);
`endif

        vecs[0]  = '{1'b1, 1'b0, 4'h0,    32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'hF,    32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'hF,    32'h14,  32'hCAFEF00D, 32'h0,        1'b0, 1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 4'hF,    32'h14,  32'h0,        32'hCAFEF00D, 1'b0, 1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'b1010, 32'h10,  32'h55667788, 32'h0,        1'b0, 2, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 4'hF,    32'h10,  32'h0,        32'h55BB77DD, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'h0,    32'h14,  32'hFFFFFFFF, 32'h0,        1'b0, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF,    32'h14,  32'h0,        32'hCAFEF00D, 1'b0, 1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'hF,    32'h102, 32'h0,        32'h0,        1'b1, 1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'hF,    32'h100, 32'h0,        32'h0,        1'b1, 1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'hF,    32'h100, 32'h12345678, 32'h0,        1'b1, 1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'b0011, 32'h103, 32'h12345678, 32'h0,        1'b1, 1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'h0,    32'h1,   32'h0,        32'h0,        1'b1, 1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'h0,    32'hFC,  32'h0,        32'h5A5A0001, 1'b0, 1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'b1000, 32'hFC,  32'h77000000, 32'h0,        1'b0, 2, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 4'h0,    32'hFC,  32'h0,        32'h775A0001, 1'b0, 1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'h0,    32'h100, 32'h0,        32'h0,        1'b1, 1, 1'b0};

        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            if (v.is_instr) begin
                instr_req = 1'b1; instr_addr = v.addr;
            end else begin
                data_req = 1'b1; data_we = v.we; data_be = v.be; data_addr = v.addr; data_wdata = v.wdata;
            end
            @(negedge clk);
            chk($sformatf("v%0d_gnt", k), v.is_instr ? instr_gnt : data_gnt, 1);
            we_seen = ram_we;
            cyc();
            instr_req = 1'b0; data_req = 1'b0;
            if (v.lat == 2) begin
                @(negedge clk);
                chk($sformatf("v%0d_early_vld", k), data_rvalid, 0);
                we_seen |= ram_we;
                cyc();
            end
            @(negedge clk);
            chk($sformatf("v%0d_vld", k), v.is_instr ? instr_rvalid : data_rvalid, 1);
            chk($sformatf("v%0d_other_vld", k), v.is_instr ? data_rvalid : instr_rvalid, 0);
            chk($sformatf("v%0d_rdata", k), v.is_instr ? instr_rdata : data_rdata, v.exp_rdata);
            chk($sformatf("v%0d_err", k), v.is_instr ? instr_err : data_err, v.exp_err);
            we_seen |= ram_we;
            chk($sformatf("v%0d_ram_we", k), we_seen, v.exp_we);
            cyc();
        end

        // Reset during the RMW write cycle abandons the store
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0001; data_addr = 32'h18; data_wdata = 32'h000000FF;
        @(negedge clk);
        chk("rrmw_gnt", data_gnt, 1);
        cyc();
        data_req = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("rrmw_we", ram_we, 0);
        chk("rrmw_dvld0", data_rvalid, 0);
        cyc();
        rstn = 1'b1; instr_req = 1'b1; instr_addr = 32'h18;
        @(negedge clk);
        chk("rrmw_dvld1", data_rvalid, 0);
        chk("rrmw_ignt", instr_gnt, 1);
        cyc();
        instr_req = 1'b0;
        @(negedge clk);
        chk("rrmw_ivld", instr_rvalid, 1);
        chk("rrmw_irdata", instr_rdata, 32'hA0A0A0A0);
        chk("rrmw_dvld2", data_rvalid, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
